spi_target: RTL and testbench
=============================

Name: spi_target

Overview:
- SPI mode-0 responder (CPOL=0, CPHA=0) that sits on the far end of the SoC's SPI master pins (spi_clk, spi_mosi, spi_miso).
- Decodes a byte-oriented read/write protocol and turns it into single-cycle accesses on a local 256-byte memory port.
- Used as a loopback/peripheral target in the test SoC and in benches for the SPI master.
- SPI pins are asynchronous to clk; they are oversampled and synchronised internally.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on spi_clk, spi_mosi and spi_cs_n (must be ≥2).
- CMD_READ, 8'h03, opcode for burst read.
- CMD_WRITE, 8'h02, opcode for burst write.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous reset, active-high.
- spi_clk  in  1  SPI serial clock from the master, async.
- spi_cs_n  in  1  chip select, active-low, async.
- spi_mosi  in  1  master-out data, async.
- spi_miso  out  1  master-in data.
- spi_miso_oe  out  1  high while selected (synchronised cs_n low).
- mem_addr  out  8  memory address.
- mem_wdata  out  8  write data.
- mem_we  out  1  one-cycle write strobe.
- mem_re  out  1  one-cycle read strobe.
- mem_rdata  in  8  read data, valid the cycle after mem_re.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, bit counter=0, shift registers=0, address=0.
  - All outputs 0. Synchronisers reset to spi_cs_n=1, spi_clk=0, spi_mosi=0.
- Clock ratio: spi_clk period must be ≥8 clk periods. Behaviour is undefined below this.
- Edge detection: rise/fall pulses come from the last two synchronised spi_clk samples.
  - MOSI is sampled on rise. MISO is updated on fall.
  - Edges are ignored while synchronised cs_n=1.
- Bit order: MSB first. A 3-bit counter increments on each rise. Byte-complete is the rise where the counter wraps 7→0.
- Transaction format:
  - Read: command, address, one dummy byte, then data bytes, each at an auto-incrementing address.
  - Write: command, address, then data bytes, each at an auto-incrementing address.
- FSM states: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
  - IDLE → CMD on synchronised cs_n falling.
  - CMD, byte-complete: byte==CMD_READ or CMD_WRITE → ADDR; any other value → IGNORE.
  - ADDR, byte-complete: latch address. Read → DUMMY and pulse mem_re for that address on the next cycle. Write → WDATA.
  - DUMMY, byte-complete → RDATA. mem_rdata (captured the cycle after mem_re) is already loaded into the TX shift register.
  - RDATA, byte-complete: address increments, mem_re pulses next cycle, and the TX register reloads the cycle after that. The reload happens before the next fall.
  - WDATA, byte-complete: on the next cycle mem_addr=address, mem_wdata=received byte, mem_we=1 for one cycle. The address increments afterwards.
  - IGNORE: consumes all bits with no memory access. spi_miso=0.
  - Any state → IDLE when synchronised cs_n rises. This is checked before edge handling in the same cycle. The bit counter clears and any partial byte is discarded; no write is issued for it.
- MISO: drives the TX register MSB in RDATA, shifting on each fall; 0 in every other state.
- Address arithmetic: 8-bit, wraps 0xFF→0x00 with no error.
- mem_re and mem_we are never high in the same cycle. Each is high for exactly one cycle per byte.
- Reset mid-transfer returns to IDLE. The next transaction requires a fresh cs_n falling edge.

Decomposition:
- Shared package spi_pkg holds:
  - CMD_READ/CMD_WRITE defaults.
  - The state enum (typedef spi_target_state_t).
  - The SPI mode constant shared with the master.
- Sub-module sync_ff (parameterised depth, reset value) is used for the three async inputs. Everything else stays in spi_target.

Test Plan:
- Write burst: cs_n low, send 02 10 AA 55, cs_n high.
  - Expect mem_we pulses with (10,AA) then (11,55). No mem_re.
- Read burst: memory[20]=3C, [21]=C3. Send 03 20 00 00 00.
  - Expect MISO bytes 00 00 00 3C C3.
  - Expect mem_re at addresses 20 and 21 (a third strobe at 22 is allowed).
- Wrap: write 02 FF 11 22.
  - Expect writes (FF,11) and (00,22).
- Unknown opcode: send 9F 01 02.
  - Expect no mem_we/mem_re and MISO=0 throughout.
- Abort: send 02 30 then 4 bits of A, then cs_n high, then a new 02 40 77.
  - Expect no write to 30 and exactly one write (40,77).
- Async reset mid-read: assert rst during a data byte.
  - Expect all outputs 0 immediately. A following read transaction works normally.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and state type for the SPI mode-0 target and its matching master.
package spi_pkg;

    localparam logic [7:0] CMD_READ_DEF  = 8'h03;
    localparam logic [7:0] CMD_WRITE_DEF = 8'h02;

    // {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        RDATA,
        WDATA,
        IGNORE
    } spi_target_state_t;

endpackage

// File: rtl/spi_target_sync_ff.sv
// Multi-stage flip-flop synchroniser for a single asynchronous input, with a
// selectable reset value so idle-high lines come out of reset inactive.
module sync_ff #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {DEPTH{RST_VAL}};
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversamples the SPI pins on clk and turns a byte-oriented
// read/write protocol into single-cycle accesses on a 256-byte memory port.
//
// state  | meaning
// IDLE   | deselected, or waiting for a fresh cs_n falling edge
// CMD    | shifting in the opcode byte
// ADDR   | shifting in the start address
// DUMMY  | read turnaround byte; first read data is fetched here
// RDATA  | shifting out read data, address auto-increments per byte
// WDATA  | shifting in write data, one memory write per byte
// IGNORE | unknown opcode; bits consumed, no memory access
module spi_target
    import spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CMD_READ    = CMD_READ_DEF,
    parameter logic [7:0] CMD_WRITE   = CMD_WRITE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_clk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    output logic       mem_re,
    input  logic [7:0] mem_rdata
);

    logic cs_s, sclk_s, mosi_s;

    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d_i(spi_cs_n), .q_o(cs_s)
    );
    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
        .clk(clk), .rst(rst), .d_i(spi_clk), .q_o(sclk_s)
    );
    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d_i(spi_mosi), .q_o(mosi_s)
    );

    spi_target_state_t state_q, state_d;
    logic       sclk_prev_q, cs_prev_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic       miso_q, miso_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       we_q, we_d;
    logic       re_q, re_d;
    logic       re_dly_q, re_dly_d;
    logic       is_read_q, is_read_d;

    logic       rise, fall, byte_done;
    logic [7:0] rx_byte;

    assign rise      = ~cs_s & sclk_s & ~sclk_prev_q;
    assign fall      = ~cs_s & ~sclk_s & sclk_prev_q;
    assign rx_byte   = {rx_q[6:0], mosi_s};
    assign byte_done = rise && (bit_cnt_q == 3'd7);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        miso_d    = miso_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
        re_dly_d  = re_q;
        is_read_d = is_read_q;

        // Post-write increment keeps mem_addr stable during the write strobe.
        if (we_q) begin
            addr_d = addr_q + 8'd1;
        end

        // Deselect wins over any edge seen in the same cycle.
        if (cs_s) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            rx_d      = 8'd0;
            miso_d    = 1'b0;
        end else if (state_q == IDLE) begin
            if (cs_prev_q) begin
                state_d   = CMD;
                bit_cnt_d = 3'd0;
                rx_d      = 8'd0;
            end
        end else begin
            if (rise) begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                rx_d      = rx_byte;
            end
            if (fall) begin
                if (state_q == RDATA) begin
                    miso_d = tx_q[7];
                    tx_d   = {tx_q[6:0], 1'b0};
                end else begin
                    miso_d = 1'b0;
                end
            end
            if (byte_done) begin
                case (state_q)
                    CMD: begin
                        if (rx_byte == CMD_READ) begin
                            state_d   = ADDR;
                            is_read_d = 1'b1;
                        end else if (rx_byte == CMD_WRITE) begin
                            state_d   = ADDR;
                            is_read_d = 1'b0;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                    ADDR: begin
                        addr_d = rx_byte;
                        if (is_read_q) begin
                            state_d = DUMMY;
                            re_d    = 1'b1;
                        end else begin
                            state_d = WDATA;
                        end
                    end
                    DUMMY: state_d = RDATA;
                    RDATA: begin
                        addr_d = addr_q + 8'd1;
                        re_d   = 1'b1;
                    end
                    WDATA: begin
                        wdata_d = rx_byte;
                        we_d    = 1'b1;
                    end
                    default: ;
                endcase
            end
        end

        // Read data arrives one cycle after the strobe and lands before the next fall.
        if (re_dly_q) begin
            tx_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 8'd0;
            tx_q        <= 8'd0;
            miso_q      <= 1'b0;
            addr_q      <= 8'd0;
            wdata_q     <= 8'd0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            re_dly_q    <= 1'b0;
            is_read_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            re_q        <= re_d;
            re_dly_q    <= re_dly_d;
            is_read_q   <= is_read_d;
        end
    end

    assign spi_miso    = (state_q == RDATA) ? miso_q : 1'b0;
    assign spi_miso_oe = ~cs_s;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_we      = we_q;
    assign mem_re      = re_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a transaction-level model predicts memory
// accesses and MISO bytes, and a per-cycle monitor checks the memory port.
module tb_spi_target;

    localparam time HALF = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_clk, spi_cs_n, spi_mosi;
    logic       spi_miso, spi_miso_oe;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we, mem_re;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mem       [256];
    logic [7:0]  model_mem [256];
    logic        mem_clr, pl_en;
    logic [7:0]  pl_addr, pl_data;
    logic [15:0] exp_wq [$];
    logic [7:0]  exp_rq [$];
    logic [7:0]  txq    [$];
    logic [7:0]  rx_log [$];
    logic        chk_miso0 = 1'b0;

    spi_target dut (
        .clk        (clk),
        .rst        (rst),
        .spi_clk    (spi_clk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory serving the DUT: writes land on the strobe edge, read data one cycle after mem_re.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem_rdata <= 8'h00;
        end else begin
            if (pl_en)  mem[pl_addr] <= pl_data;
            if (mem_we) mem[mem_addr] <= mem_wdata;
            if (mem_re) mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pl_addr      = a;
        pl_data      = d;
        pl_en        = 1'b1;
        model_mem[a] = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic spi_bits(input logic [7:0] v, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = v[i];
            #HALF;
            rx = {rx[6:0], spi_miso};
            spi_clk = 1'b1;
            #HALF;
            spi_clk = 1'b0;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " miso"},      spi_miso,    0);
        check({tag, " miso_oe"},   spi_miso_oe, 0);
        check({tag, " mem_addr"},  mem_addr,    0);
        check({tag, " mem_wdata"}, mem_wdata,   0);
        check({tag, " mem_we"},    mem_we,      0);
        check({tag, " mem_re"},    mem_re,      0);
    endtask

    // Predicts the transaction in txq, plays it on the pins, then checks MISO and leftovers.
    task automatic run_txn(input string name);
        logic [7:0] exp_miso [$];
        logic [7:0] a, rx;
        int         nd;
        a = (txq.size() > 1) ? txq[1] : 8'h00;
        if (txq[0] == 8'h02) begin
            for (int k = 0; k < txq.size(); k++) exp_miso.push_back(8'h00);
            for (int k = 2; k < txq.size(); k++) begin
                exp_wq.push_back({a, txq[k]});
                model_mem[a] = txq[k];
                a = a + 8'd1;
            end
            chk_miso0 = 1'b1;
        end else if (txq[0] == 8'h03 && txq.size() >= 3) begin
            nd = txq.size() - 3;
            for (int k = 0; k < 3; k++) exp_miso.push_back(8'h00);
            for (int k = 0; k <= nd; k++) exp_rq.push_back(a + 8'(k));
            for (int k = 0; k < nd; k++) exp_miso.push_back(model_mem[a + 8'(k)]);
        end else begin
            for (int k = 0; k < txq.size(); k++) exp_miso.push_back(8'h00);
            chk_miso0 = 1'b1;
        end

        rx_log.delete();
        spi_cs_n = 1'b0;
        #HALF;
        for (int k = 0; k < txq.size(); k++) begin
            spi_bits(txq[k], 8, rx);
            rx_log.push_back(rx);
            check($sformatf("%s miso byte %0d", name, k), rx, exp_miso[k]);
        end
        #HALF;
        spi_cs_n = 1'b1;
        #(4 * HALF);
        chk_miso0 = 1'b0;
        check({name, " writes outstanding"}, exp_wq.size(), 0);
        // One trailing prefetch strobe past the last data byte is tolerated.
        check({name, " reads outstanding <=1"}, 32'(exp_rq.size() <= 1), 1);
        exp_rq.delete();
        txq.delete();
    endtask

    initial begin
        logic [7:0] rx;
        rst      = 1'b1;
        mem_clr  = 1'b1;
        pl_en    = 1'b0;
        pl_addr  = 8'h00;
        pl_data  = 8'h00;
        spi_clk  = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;

        fork
            begin : monitor
                logic        we_prev, re_prev;
                logic [15:0] w;
                logic [7:0]  ra;
                we_prev = 1'b0;
                re_prev = 1'b0;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        we_prev = 1'b0;
                        re_prev = 1'b0;
                    end else begin
                        if (mem_we || mem_re)
                            check("we/re exclusive", 32'(!(mem_we && mem_re)), 1);
                        if (mem_we) begin
                            check("we single cycle", we_prev, 0);
                            if (exp_wq.size() == 0) begin
                                n_checks++;
                                n_fail++;
                                $display("FAIL unexpected write: addr %0h data %0h, expected none", mem_addr, mem_wdata);
                            end else begin
                                w = exp_wq.pop_front();
                                check("write addr", mem_addr, w[15:8]);
                                check("write data", mem_wdata, w[7:0]);
                            end
                        end
                        if (mem_re) begin
                            check("re single cycle", re_prev, 0);
                            if (exp_rq.size() == 0) begin
                                n_checks++;
                                n_fail++;
                                $display("FAIL unexpected read: addr %0h, expected none", mem_addr);
                            end else begin
                                ra = exp_rq.pop_front();
                                check("read addr", mem_addr, ra);
                            end
                        end
                        if (chk_miso0) check("miso held low", spi_miso, 0);
                        we_prev = mem_we;
                        re_prev = mem_re;
                    end
                end
            end
        join_none

        #23;
        check_outputs_zero("reset");
        rst     = 1'b0;
        mem_clr = 1'b0;
        #20;

        // Write burst
        txq = {8'h02, 8'h10, 8'hAA, 8'h55};
        run_txn("write burst");
        check("mem[10] after write", mem[8'h10], 8'hAA);
        check("mem[11] after write", mem[8'h11], 8'h55);

        // Read burst
        preload(8'h20, 8'h3C);
        preload(8'h21, 8'hC3);
        txq = {8'h03, 8'h20, 8'h00, 8'h00, 8'h00};
        run_txn("read burst");
        check("read byte 3 literal", rx_log[3], 8'h3C);
        check("read byte 4 literal", rx_log[4], 8'hC3);

        // Address wrap
        txq = {8'h02, 8'hFF, 8'h11, 8'h22};
        run_txn("wrap write");
        check("mem[FF] after wrap", mem[8'hFF], 8'h11);
        check("mem[00] after wrap", mem[8'h00], 8'h22);

        // Unknown opcode
        txq = {8'h9F, 8'h01, 8'h02};
        run_txn("unknown opcode");

        // Abort mid-byte, then a clean write
        preload(8'h30, 8'h5A);
        spi_cs_n = 1'b0;
        #HALF;
        spi_bits(8'h02, 8, rx);
        spi_bits(8'h30, 8, rx);
        spi_bits(8'hA0, 4, rx);
        #HALF;
        spi_cs_n = 1'b1;
        #(4 * HALF);
        check("mem[30] untouched by abort", mem[8'h30], 8'h5A);
        txq = {8'h02, 8'h40, 8'h77};
        run_txn("write after abort");
        check("mem[40] after abort", mem[8'h40], 8'h77);

        // Async reset in the middle of a read data byte
        exp_rq.push_back(8'h20);
        spi_cs_n = 1'b0;
        #HALF;
        spi_bits(8'h03, 8, rx);
        spi_bits(8'h20, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'hFF, 4, rx);
        #22;
        rst = 1'b1;
        #1;
        check_outputs_zero("mid-read reset");
        spi_cs_n = 1'b1;
        spi_clk  = 1'b0;
        #40;
        rst = 1'b0;
        exp_rq.delete();
        #43;
        txq = {8'h03, 8'h21, 8'h00, 8'h00};
        run_txn("read after reset");
        check("read after reset literal", rx_log[3], 8'hC3);

        #100;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
